// File: rtl/port_alloc_unit_rr.sv
// Round-robin write-port-group allocator with store-order FIFO, load tracking and op3 read-port reservation.
// Optional feature macro: PAU_SKIP_BUSY_EN (selection skips busy port groups instead of waiting on the pointer).
module port_alloc_unit_rr #(
  parameter int R_PORTS_NUM        = 8,
  parameter int W_PORTS_NUM        = 4,
  parameter int MAX_ST_OUTSTANDING = 2,
  parameter int MAX_LD_OUTSTANDING = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [11:0]                    instr_vld_i,
  output logic [11:0]                    instr_rdy_o,
  input  logic                           vrf_starting_addr_vld_i,
  input  logic [W_PORTS_NUM-1:0]         dependancy_issue_i,
  input  logic [W_PORTS_NUM-1:0]         port_rdy_i,
  output logic [W_PORTS_NUM-1:0]         start_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] alloc_port_o,
  output logic                           alloc_port_vld_o,
  output logic [$clog2(R_PORTS_NUM)-1:0] op3_port_sel_o,
  output logic                           op3_port_vld_o,
  output logic [$clog2(W_PORTS_NUM)-1:0] store_driver_o,
  output logic                           store_driver_vld_o
);

  localparam int PW    = $clog2(W_PORTS_NUM);
  localparam int RW    = $clog2(R_PORTS_NUM);
  localparam int OP3_N = (W_PORTS_NUM < R_PORTS_NUM / 2) ? W_PORTS_NUM : R_PORTS_NUM / 2;
  localparam int SW    = (MAX_ST_OUTSTANDING > 1) ? $clog2(MAX_ST_OUTSTANDING) : 1;
  localparam int SCW   = $clog2(MAX_ST_OUTSTANDING + 1);
  localparam int LCW   = $clog2(MAX_LD_OUTSTANDING + W_PORTS_NUM + 1);

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          sel;
  logic [PW-1:0]          st_mem [MAX_ST_OUTSTANDING];
  logic [SW-1:0]          st_rd;
  logic [SW-1:0]          st_wr;
  logic [SCW-1:0]         st_cnt;
  logic [LCW-1:0]         ld_cnt;
  logic [LCW-1:0]         ld_dec;
  logic [W_PORTS_NUM-1:0] load_busy;
  logic [W_PORTS_NUM-1:0] ld_done;
  logic [W_PORTS_NUM-1:0] ld_set;
  logic [W_PORTS_NUM-1:0] op3_busy;
  logic [W_PORTS_NUM-1:0] op3_set;
  logic [W_PORTS_NUM-1:0] start;
  logic [PW-1:0]          head;
  logic [PW-1:0]          op3_idx;
  logic                   op3_found;
  logic                   no_dep;
  logic                   any_rdy;
  logic                   base;
  logic                   sel_ok;
  logic                   st_full;
  logic                   st_empty;
  logic                   ld_ok;
  logic [10:0]            rdy_lo;
  logic                   rdy_cfg;
  logic                   issue;
  logic                   st_push;
  logic                   st_pop;
  logic                   ld_fire;
  logic                   op3_fire;
  logic                   unused_cfg_vld;

  // Config valid only gates readiness externally; it never triggers an allocation.
  assign unused_cfg_vld = instr_vld_i[11];

  assign no_dep   = (dependancy_issue_i == '0);
  assign any_rdy  = |port_rdy_i;
  assign base     = !rst && no_dep && any_rdy;
  assign st_full  = (st_cnt == SCW'(MAX_ST_OUTSTANDING));
  assign st_empty = (st_cnt == '0);
  assign head     = st_mem[st_rd];
  assign ld_ok    = (int'(ld_cnt) < MAX_LD_OUTSTANDING);

`ifdef PAU_SKIP_BUSY_EN
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] b, input int k);
    int s;
    s = int'(b) + k;
    if (s >= W_PORTS_NUM) s = s - W_PORTS_NUM;
    return PW'(s);
  endfunction

  // Scan downwards so the nearest ready group after the pointer wins.
  always_comb begin
    sel = ptr;
    for (int k = W_PORTS_NUM - 1; k >= 0; k--)
      if (port_rdy_i[wrap_add(ptr, k)]) sel = wrap_add(ptr, k);
  end

  assign sel_ok = any_rdy;
`else
  assign sel    = ptr;
  assign sel_ok = port_rdy_i[sel];
`endif

  always_comb begin
    op3_found = 1'b0;
    op3_idx   = '0;
    for (int i = OP3_N - 1; i >= 0; i--) begin
      if (port_rdy_i[i] && !op3_busy[i] && (PW'(i) != sel)) begin
        op3_found = 1'b1;
        op3_idx   = PW'(i);
      end
    end
  end

  assign rdy_lo[1:0]  = {2{base && op3_found}};
  assign rdy_lo[3:2]  = {2{base && !st_full}};
  assign rdy_lo[5:4]  = {2{base && ld_ok && (instr_vld_i[3:2] == 2'b00)}};
  assign rdy_lo[10:6] = {5{base}};

  assign issue    = !rst && vrf_starting_addr_vld_i && no_dep && sel_ok && |(instr_vld_i[10:0] & rdy_lo);
  assign st_push  = issue && |(instr_vld_i[3:2] & rdy_lo[3:2]);
  assign ld_fire  = issue && |(instr_vld_i[5:4] & rdy_lo[5:4]);
  assign op3_fire = issue && |(instr_vld_i[1:0] & rdy_lo[1:0]);
  assign st_pop   = !st_empty && port_rdy_i[head] && !(st_push && (sel == head));

  always_comb begin
    start   = '0;
    ld_set  = '0;
    op3_set = '0;
    if (issue)    start[sel]       = 1'b1;
    if (ld_fire)  ld_set[sel]      = 1'b1;
    if (op3_fire) op3_set[op3_idx] = 1'b1;
  end

  assign rdy_cfg = base && (&port_rdy_i) && st_empty && (ld_cnt == '0) &&
                   (op3_busy == '0) && (start == '0);

  // Each tracked load retires once its port reports idle; a new load on the same port keeps it busy.
  assign ld_done = load_busy & port_rdy_i;

  always_comb begin
    ld_dec = '0;
    for (int i = 0; i < W_PORTS_NUM; i++) ld_dec = ld_dec + LCW'(ld_done[i]);
  end

  assign instr_rdy_o        = {rdy_cfg, rdy_lo};
  assign start_o            = start;
  assign alloc_port_vld_o   = issue;
  assign alloc_port_o       = rst ? '0 : sel;
  assign op3_port_vld_o     = !rst && op3_found;
  assign op3_port_sel_o     = rst ? '0 : RW'(op3_idx);
  assign store_driver_vld_o = !rst && !st_empty;
  assign store_driver_o     = rst ? '0 : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      st_rd     <= '0;
      st_wr     <= '0;
      st_cnt    <= '0;
      ld_cnt    <= '0;
      load_busy <= '0;
      op3_busy  <= '0;
      for (int i = 0; i < MAX_ST_OUTSTANDING; i++) st_mem[i] <= '0;
    end else begin
      if (issue) ptr <= (sel == PW'(W_PORTS_NUM - 1)) ? '0 : sel + PW'(1);
      if (st_push) begin
        st_mem[st_wr] <= sel;
        st_wr         <= (st_wr == SW'(MAX_ST_OUTSTANDING - 1)) ? '0 : st_wr + SW'(1);
      end
      if (st_pop) st_rd <= (st_rd == SW'(MAX_ST_OUTSTANDING - 1)) ? '0 : st_rd + SW'(1);
      if (st_push && !st_pop)      st_cnt <= st_cnt + SCW'(1);
      else if (st_pop && !st_push) st_cnt <= st_cnt - SCW'(1);
      load_busy <= (load_busy & ~ld_done) | ld_set;
      ld_cnt    <= ld_cnt + LCW'(ld_fire) - ld_dec;
      op3_busy  <= (op3_busy & ~port_rdy_i) | op3_set;
    end
  end

endmodule

// File: tb/tb_port_alloc_unit_rr.sv
// Testbench for port_alloc_unit_rr: directed scenarios with literal expectations plus a per-cycle behavioural model.
module tb_port_alloc_unit_rr;

  localparam int R     = 8;
  localparam int W     = 4;
  localparam int MST   = 2;
  localparam int MLD   = 1;
  localparam int PW    = $clog2(W);
  localparam int RW    = $clog2(R);
  localparam int OP3_N = (W < R / 2) ? W : R / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   instr_vld_i = '0;
  logic [11:0]   instr_rdy_o;
  logic          vrf_starting_addr_vld_i = 1'b1;
  logic [W-1:0]  dependancy_issue_i = '0;
  logic [W-1:0]  port_rdy_i = '1;
  logic [W-1:0]  start_o;
  logic [PW-1:0] alloc_port_o;
  logic          alloc_port_vld_o;
  logic [RW-1:0] op3_port_sel_o;
  logic          op3_port_vld_o;
  logic [PW-1:0] store_driver_o;
  logic          store_driver_vld_o;

  int checks = 0;
  int errors = 0;

  port_alloc_unit_rr #(
    .R_PORTS_NUM(R), .W_PORTS_NUM(W), .MAX_ST_OUTSTANDING(MST), .MAX_LD_OUTSTANDING(MLD)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_vld_i(instr_vld_i), .instr_rdy_o(instr_rdy_o),
    .vrf_starting_addr_vld_i(vrf_starting_addr_vld_i),
    .dependancy_issue_i(dependancy_issue_i), .port_rdy_i(port_rdy_i),
    .start_o(start_o), .alloc_port_o(alloc_port_o), .alloc_port_vld_o(alloc_port_vld_o),
    .op3_port_sel_o(op3_port_sel_o), .op3_port_vld_o(op3_port_vld_o),
    .store_driver_o(store_driver_o), .store_driver_vld_o(store_driver_vld_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Inputs change just after the rising edge; the trailing delay lets combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic [11:0] vld, input logic [W-1:0] prdy);
    @(posedge clk);
    #1;
    rst         = r;
    instr_vld_i = vld;
    port_rdy_i  = prdy;
    #1;
  endtask

  // Reference model: allocation pointer, queue of store ports, load count and per-port busy flags.
  int           m_ptr = 0;
  int           m_q[$];
  int           m_ld = 0;
  bit [W-1:0]   m_ldb = '0;
  bit [W-1:0]   m_op3b = '0;

  always @(negedge clk) begin : model
    int          sel;
    int          op3_sel;
    bit          op3_ok;
    bit          found;
    bit          no_dep;
    bit          any_rdy;
    bit          issue;
    bit          st_fire;
    bit          ld_fire;
    bit          op3_fire;
    bit          pop;
    logic [11:0] e_rdy;
    logic [W-1:0] e_start;
    if (rst) begin
      checkOutput("rst_start", start_o, 0);
      checkOutput("rst_rdy", instr_rdy_o, 0);
      checkOutput("rst_alloc_vld", alloc_port_vld_o, 0);
      checkOutput("rst_alloc_port", alloc_port_o, 0);
      checkOutput("rst_op3_vld", op3_port_vld_o, 0);
      checkOutput("rst_op3_sel", op3_port_sel_o, 0);
      checkOutput("rst_st_vld", store_driver_vld_o, 0);
      checkOutput("rst_st_drv", store_driver_o, 0);
      m_ptr = 0; m_q.delete(); m_ld = 0; m_ldb = '0; m_op3b = '0;
    end else begin
      no_dep  = (dependancy_issue_i == '0);
      any_rdy = (port_rdy_i != '0);
      sel     = m_ptr;
`ifdef PAU_SKIP_BUSY_EN
      found = 1'b0;
      for (int k = 0; k < W; k++)
        if (!found && port_rdy_i[(m_ptr + k) % W]) begin
          sel   = (m_ptr + k) % W;
          found = 1'b1;
        end
`endif
      op3_ok = 1'b0; op3_sel = 0;
      for (int i = 0; i < OP3_N; i++)
        if (!op3_ok && port_rdy_i[i] && !m_op3b[i] && i != sel) begin
          op3_ok  = 1'b1;
          op3_sel = i;
        end
      e_rdy = '0;
      for (int b = 0; b < 11; b++) begin
        if (b < 2)      e_rdy[b] = no_dep && any_rdy && op3_ok;
        else if (b < 4) e_rdy[b] = no_dep && any_rdy && (m_q.size() < MST);
        else if (b < 6) e_rdy[b] = no_dep && any_rdy && (m_ld < MLD) && (instr_vld_i[3:2] == 2'b00);
        else            e_rdy[b] = no_dep && any_rdy;
      end
`ifdef PAU_SKIP_BUSY_EN
      issue = vrf_starting_addr_vld_i && no_dep && any_rdy && ((instr_vld_i[10:0] & e_rdy[10:0]) != 0);
`else
      issue = vrf_starting_addr_vld_i && no_dep && port_rdy_i[sel] && ((instr_vld_i[10:0] & e_rdy[10:0]) != 0);
`endif
      e_start = '0;
      if (issue) e_start[sel] = 1'b1;
      e_rdy[11] = no_dep && (port_rdy_i == '1) && (m_q.size() == 0) && (m_ld == 0) &&
                  (m_op3b == '0) && (e_start == '0);

      checkOutput("rdy", instr_rdy_o, e_rdy);
      checkOutput("start", start_o, e_start);
      checkOutput("alloc_vld", alloc_port_vld_o, issue);
      checkOutput("alloc_port", alloc_port_o, sel);
      checkOutput("op3_vld", op3_port_vld_o, op3_ok);
      if (op3_ok) checkOutput("op3_sel", op3_port_sel_o, op3_sel);
      checkOutput("st_vld", store_driver_vld_o, m_q.size() != 0);
      if (m_q.size() != 0) checkOutput("st_drv", store_driver_o, m_q[0]);

      st_fire  = issue && ((instr_vld_i[3:2] & e_rdy[3:2]) != 0);
      ld_fire  = issue && ((instr_vld_i[5:4] & e_rdy[5:4]) != 0);
      op3_fire = issue && ((instr_vld_i[1:0] & e_rdy[1:0]) != 0);
      pop = (m_q.size() != 0) && port_rdy_i[m_q[0]] && !(st_fire && sel == m_q[0]);
      if (issue) m_ptr = (sel + 1) % W;
      if (pop) void'(m_q.pop_front());
      if (st_fire) m_q.push_back(sel);
      for (int p = 0; p < W; p++)
        if (m_ldb[p] && port_rdy_i[p]) begin
          m_ldb[p] = 1'b0;
          m_ld--;
        end
      if (ld_fire) begin
        m_ldb[sel] = 1'b1;
        m_ld++;
      end
      for (int p = 0; p < W; p++)
        if (port_rdy_i[p]) m_op3b[p] = 1'b0;
      if (op3_fire) m_op3b[op3_sel] = 1'b1;
    end
  end

  int exp_start [5] = '{1, 2, 4, 8, 1};

  initial begin
    // Reset and idle readiness
    applyStimulus(1'b1, 12'h000, 4'hF);
    checkOutput("reset_start", start_o, 0);
    checkOutput("reset_rdy", instr_rdy_o, 0);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("idle_rdy", instr_rdy_o, 12'hFFF);
    checkOutput("idle_alloc_vld", alloc_port_vld_o, 0);
    checkOutput("idle_st_vld", store_driver_vld_o, 0);

    // Round-robin rotation with wrap
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 12'h040, 4'hF);
      checkOutput("rr_start", start_o, exp_start[i]);
      checkOutput("rr_port", alloc_port_o, i % 4);
    end

    // Pointer sits on a busy port (ptr = 1)
    applyStimulus(1'b0, 12'h040, 4'b1101);
`ifdef PAU_SKIP_BUSY_EN
    checkOutput("skip_start", start_o, 4'b0100);
    checkOutput("skip_port", alloc_port_o, 2);
    applyStimulus(1'b0, 12'h040, 4'b1101);
    checkOutput("skip_start2", start_o, 4'b1000);
`else
    checkOutput("stall_start", start_o, 0);
    checkOutput("stall_vld", alloc_port_vld_o, 0);
    applyStimulus(1'b0, 12'h040, 4'b1101);
    checkOutput("stall_start2", start_o, 0);
`endif

    // Store FIFO fill, full back-pressure and pop
    applyStimulus(1'b1, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h004, 4'hF);
    checkOutput("st_a_start", start_o, 4'b0001);
    applyStimulus(1'b0, 12'h004, 4'b1110);
    checkOutput("st_b_start", start_o, 4'b0010);
    checkOutput("st_b_drv", store_driver_o, 0);
    checkOutput("st_b_vld", store_driver_vld_o, 1);
    applyStimulus(1'b0, 12'h004, 4'b1100);
    checkOutput("st_full_rdy", instr_rdy_o[3:2], 2'b00);
    checkOutput("st_full_drv", store_driver_o, 0);
    checkOutput("st_full_start", start_o, 0);
    applyStimulus(1'b0, 12'h000, 4'b1101);
    checkOutput("st_pop_rdy", instr_rdy_o[3:2], 2'b00);
    applyStimulus(1'b0, 12'h000, 4'b1101);
    checkOutput("st_after_pop_drv", store_driver_o, 1);
    checkOutput("st_after_pop_rdy", instr_rdy_o[3:2], 2'b11);
    applyStimulus(1'b0, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("st_drained", store_driver_vld_o, 0);

    // Store has priority over load
    applyStimulus(1'b1, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h014, 4'hF);
    checkOutput("prio_ld_rdy", instr_rdy_o[5:4], 2'b00);
    checkOutput("prio_start", start_o, 4'b0001);
    applyStimulus(1'b0, 12'h000, 4'b1110);
    checkOutput("prio_st_vld", store_driver_vld_o, 1);
    checkOutput("prio_st_drv", store_driver_o, 0);

    // Single outstanding load
    applyStimulus(1'b1, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h010, 4'hF);
    checkOutput("ld_start", start_o, 4'b0001);
    checkOutput("ld_rdy0", instr_rdy_o[5:4], 2'b11);
    applyStimulus(1'b0, 12'h000, 4'b1110);
    checkOutput("ld_busy_rdy", instr_rdy_o[5:4], 2'b00);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("ld_done_rdy", instr_rdy_o[5:4], 2'b00);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("ld_free_rdy", instr_rdy_o[5:4], 2'b11);

    // Op3 read port reservation
    applyStimulus(1'b1, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h001, 4'b0111);
    checkOutput("op3_a_sel", op3_port_sel_o, 1);
    checkOutput("op3_a_vld", op3_port_vld_o, 1);
    checkOutput("op3_a_start", start_o, 4'b0001);
    applyStimulus(1'b0, 12'h001, 4'b0110);
    checkOutput("op3_b_sel", op3_port_sel_o, 2);
    checkOutput("op3_b_start", start_o, 4'b0010);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("op3_busy_cfg", instr_rdy_o[11], 0);
    applyStimulus(1'b0, 12'h000, 4'hF);
    checkOutput("op3_free_cfg", instr_rdy_o[11], 1);

    // Config gating and reset mid-store
    applyStimulus(1'b1, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h004, 4'hF);
    checkOutput("cfg_st_start", start_o, 4'b0001);
    applyStimulus(1'b0, 12'h800, 4'b1110);
    checkOutput("cfg_blk1", instr_rdy_o[11], 0);
    checkOutput("cfg_no_alloc", alloc_port_vld_o, 0);
    applyStimulus(1'b0, 12'h800, 4'hF);
    checkOutput("cfg_blk2", instr_rdy_o[11], 0);
    applyStimulus(1'b0, 12'h800, 4'hF);
    checkOutput("cfg_ok", instr_rdy_o[11], 1);
    applyStimulus(1'b0, 12'h004, 4'hF);
    checkOutput("mid_st_start", start_o, 4'b0010);
    applyStimulus(1'b0, 12'h000, 4'b1101);
    checkOutput("mid_st_vld", store_driver_vld_o, 1);
    checkOutput("mid_st_drv", store_driver_o, 1);
    applyStimulus(1'b1, 12'h000, 4'b1101);
    checkOutput("mid_rst_vld", store_driver_vld_o, 0);
    applyStimulus(1'b0, 12'h000, 4'b1101);
    checkOutput("post_rst_vld", store_driver_vld_o, 0);
    checkOutput("post_rst_cfg", instr_rdy_o[11], 0);

    applyStimulus(1'b0, 12'h000, 4'hF);
    applyStimulus(1'b0, 12'h000, 4'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
